// File: rtl/periplex_uart_rx_scheduler_if.sv
// ---------------------------------------------------------------------------
// periplex_uart_rx_scheduler_if
// Bundles the receive-side, transmit-side and status signals of the
// UART receive scheduler.
//   rx_data  [8*NUM_CH] received bytes, channel i at [8*i+7:8*i]
//   rx_valid [NUM_CH]   one-cycle strobe per channel
//   tx_data  [8]        byte to the shared test-UART transmitter
//   tx_valid            tx_data valid
//   tx_ready            transmitter accepts tx_data this cycle
//   ovf_clr             clears all overflow flags
//   ovf      [NUM_CH]   sticky per-channel overflow flags
//   hold                flow-control: some FIFO at/above the hold level
//   led                 OR of all overflow flags
// slave  = scheduler side, master = environment side.
// ---------------------------------------------------------------------------
interface periplex_uart_rx_scheduler_if #(
  parameter int NUM_CH = 3
);
  logic [8*NUM_CH-1:0] rx_data;
  logic [NUM_CH-1:0]   rx_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                ovf_clr;
  logic [NUM_CH-1:0]   ovf;
  logic                hold;
  logic                led;

  modport slave (
    input  rx_data, rx_valid, tx_ready, ovf_clr,
    output tx_data, tx_valid, ovf, hold, led
  );

  modport master (
    output rx_data, rx_valid, tx_ready, ovf_clr,
    input  tx_data, tx_valid, ovf, hold, led
  );
endinterface

// File: rtl/periplex_uart_rx_scheduler.sv
// ---------------------------------------------------------------------------
// periplex_uart_rx_scheduler
// Shares one test-UART transmitter among NUM_CH UART receivers. Each
// received byte is buffered in a per-channel FIFO; a round-robin scheduler
// sends every byte as a two-byte frame {HDR_TAG, ch} followed by the data.
// Ports:
//   clk1  sole clock, rising edge
//   rst   synchronous reset, active-high
//   bus   scheduler side of periplex_uart_rx_scheduler_if (see that file)
// ---------------------------------------------------------------------------
module periplex_uart_rx_scheduler #(
  parameter int         NUM_CH     = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter int         HOLD_LEVEL = 3,
  parameter logic [5:0] HDR_TAG    = 6'b101010
) (
  input  logic                            clk1,
  input  logic                            rst,
  periplex_uart_rx_scheduler_if.slave     bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q    [NUM_CH][FIFO_DEPTH];
  ptr_t              wr_ptr_q [NUM_CH];
  ptr_t              rd_ptr_q [NUM_CH];
  cnt_t              cnt_q    [NUM_CH];
  cnt_t              cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] push, pop, ovf_set;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              hold_q, hold_d;
  logic [7:0]        head_data;

  // Scheduler state
  state_t     state_q;
  logic [1:0] ch_q;
  logic [1:0] last_grant_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       grant_vld;
  logic [1:0] grant_ch;

  // Push/pop decode. Fullness is judged on the registered count, so a pop
  // of the same channel in the same cycle never rescues an incoming byte.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    push      = '0;
    pop       = '0;
    ovf_set   = '0;
    hold_d    = 1'b0;
    head_data = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i]    = bus.rx_valid[i] && (cnt_q[i] != cnt_t'(FIFO_DEPTH));
      ovf_set[i] = bus.rx_valid[i] && (cnt_q[i] == cnt_t'(FIFO_DEPTH));
      pop[i]     = (state_q == DATA) && bus.tx_ready && (ch_q == 2'(i));
      cnt_d[i]   = cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
      if (cnt_d[i] >= cnt_t'(HOLD_LEVEL)) hold_d = 1'b1;
      if (ch_q == 2'(i)) head_data = mem_q[i][rd_ptr_q[i]];
    end
    // A new overflow in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~{NUM_CH{bus.ovf_clr}});
  end

  // Round-robin: first non-empty channel after the last one served.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = 2'd0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_vld && (cnt_q[(int'(last_grant_q) + k) % NUM_CH] != '0)) begin
        grant_vld = 1'b1;
        grant_ch  = 2'((int'(last_grant_q) + k) % NUM_CH);
      end
    end
  end

  // NOTE: the data array has no reset; stale contents are unreachable
  // because the pointers and counts are reset.
  always_ff @(posedge clk1) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.rx_data[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Power-of-two depth: pointers wrap naturally.
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + ptr_t'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + ptr_t'(1);
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q  <= ovf_d;
      hold_q <= hold_d;
    end
  end

  // Frame FSM with registered tx outputs; outputs only move on acceptance
  // or while idle, so they are stable under backpressure.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= 2'd0;
      last_grant_q <= 2'(NUM_CH - 1);
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            ch_q       <= grant_ch;
            tx_data_q  <= {HDR_TAG, grant_ch};
            tx_valid_q <= 1'b1;
            state_q    <= HDR;
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            tx_data_q <= head_data;
            state_q   <= DATA;
          end
        end
        DATA: begin
          // The FIFO pop happens in the same cycle (see pop decode).
          if (bus.tx_ready) begin
            last_grant_q <= ch_q;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.ovf      = ovf_q;
  assign bus.hold     = hold_q;
  assign bus.led      = |ovf_q;

endmodule
